// File: rtl/apu_clk_pkg.sv
// Shared constants for the APU clock tree: divider presets, counter sizing
// and the values every clock output takes while n_RES is low.
package apu_clk_pkg;

  localparam int NTSC_DIV = 12;
  localparam int PAL_DIV  = 16;

  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  localparam logic RST_PHI0      = 1'b0;
  localparam logic RST_PHI1      = 1'b1;
  localparam logic RST_PHI2      = 1'b0;
  localparam logic RST_M2        = 1'b0;
  localparam logic RST_ACLK1     = 1'b0;
  localparam logic RST_NACLK2    = 1'b1;
  localparam logic RST_CYC_START = 1'b0;

endpackage

// File: rtl/apu_aclk_phase.sv
// Even/odd CPU-cycle tracker and the half-rate APU clock pair derived from it.
module apu_aclk_phase
  import apu_clk_pkg::*;
(
  input  logic CLK,
  input  logic n_RES,
  input  logic phi1_next,
  input  logic cyc_start_next,
  output logic ACLK1,
  output logic nACLK2
);

  logic odd;
  logic odd_next;

  // The toggle lands on the rise that opens a CPU cycle, never on the div wrap.
  always_comb begin
    odd_next = cyc_start_next ? ~odd : odd;
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      odd    <= 1'b1;
      ACLK1  <= RST_ACLK1;
      nACLK2 <= RST_NACLK2;
    end else begin
      odd    <= odd_next;
      ACLK1  <= phi1_next & ~odd_next;
      nACLK2 <= ~(phi1_next & odd_next);
    end
  end

endmodule

// File: rtl/apu_phi_aclk_gen.sv
// Divides the master CLK into the CPU phase clocks, the M2 bus clock and the
// APU half-rate clocks; every output comes straight from a flop.
module apu_phi_aclk_gen
  import apu_clk_pkg::*;
#(
  parameter int CPU_DIV = NTSC_DIV,
  parameter int M2_HOLD = 1
) (
  input  logic CLK,
  input  logic n_RES,
  output logic PHI0,
  output logic PHI1,
  output logic PHI2,
  output logic M2,
  output logic ACLK1,
  output logic nACLK2,
  output logic CYC_START
);

  localparam int              DW       = div_width(CPU_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CPU_DIV - 1);
  localparam logic [DW-1:0] PHI_END  = DW'(CPU_DIV / 2);
  localparam logic [DW-1:0] M2_END   = DW'(CPU_DIV / 2 + M2_HOLD);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic          phi0_next;
  logic          phi1_next;
  logic          m2_next;
  logic          cyc_next;

  // Outputs are decoded from the next count so they line up with div after the rise;
  // any out-of-range count falls back to 0.
  always_comb begin
    div_next  = (div >= DIV_LAST) ? '0 : div + DW'(1);
    phi0_next = (div_next != '0) && (div_next <= PHI_END);
    phi1_next = ~phi0_next;
    m2_next   = (div_next != '0) && (div_next <= M2_END);
    cyc_next  = (div_next == DW'(1));
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      div       <= '0;
      PHI0      <= RST_PHI0;
      PHI1      <= RST_PHI1;
      PHI2      <= RST_PHI2;
      M2        <= RST_M2;
      CYC_START <= RST_CYC_START;
    end else begin
      div       <= div_next;
      PHI0      <= phi0_next;
      PHI1      <= phi1_next;
      PHI2      <= phi0_next;
      M2        <= m2_next;
      CYC_START <= cyc_next;
    end
  end

  apu_aclk_phase u_aclk_phase (
    .CLK            (CLK),
    .n_RES          (n_RES),
    .phi1_next      (phi1_next),
    .cyc_start_next (cyc_next),
    .ACLK1          (ACLK1),
    .nACLK2         (nACLK2)
  );

endmodule

// File: tb/tb_apu_phi_aclk_gen.sv
// Bench for apu_phi_aclk_gen: an NTSC and a PAL instance share CLK and n_RES and
// are compared against an arithmetic model of the clock tree indexed by rise count.
module tb_apu_phi_aclk_gen;

  localparam int PAL_HOLD = 3;
  localparam logic [6:0] RST_VEC = 7'b0100010;

  logic clk = 1'b0;
  logic n_res = 1'b0;
  int   k = 0;
  int   total = 0;
  int   bad = 0;

  logic n_phi0, n_phi1, n_phi2, n_m2, n_aclk1, n_naclk2, n_cyc;
  logic p_phi0, p_phi1, p_phi2, p_m2, p_aclk1, p_naclk2, p_cyc;

  // Bit order: {PHI0, PHI1, PHI2, M2, ACLK1, nACLK2, CYC_START}
  wire [6:0] obs_n = {n_phi0, n_phi1, n_phi2, n_m2, n_aclk1, n_naclk2, n_cyc};
  wire [6:0] obs_p = {p_phi0, p_phi1, p_phi2, p_m2, p_aclk1, p_naclk2, p_cyc};

  logic [6:0] sn[0:72];
  logic [6:0] sp[0:72];
  logic [6:0] exp_q[$];

  apu_phi_aclk_gen #(.CPU_DIV(12), .M2_HOLD(1)) u_ntsc (
    .CLK(clk), .n_RES(n_res), .PHI0(n_phi0), .PHI1(n_phi1), .PHI2(n_phi2),
    .M2(n_m2), .ACLK1(n_aclk1), .nACLK2(n_naclk2), .CYC_START(n_cyc)
  );

  apu_phi_aclk_gen #(.CPU_DIV(16), .M2_HOLD(PAL_HOLD)) u_pal (
    .CLK(clk), .n_RES(n_res), .PHI0(p_phi0), .PHI1(p_phi1), .PHI2(p_phi2),
    .M2(p_m2), .ACLK1(p_aclk1), .nACLK2(p_naclk2), .CYC_START(p_cyc)
  );

  // Clock and rise counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge n_res) begin
    if (!n_res) k <= 0;
    else        k <= k + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1);
  end

  // Reference model: outputs after kk rises since reset release.
  function automatic logic [6:0] model(input int kk, input int div, input int hold);
    int   d;
    int   c;
    logic phi0, m2, cyc, odd;
    if (kk == 0) return RST_VEC;
    d    = kk % div;
    phi0 = (d >= 1) && (d <= div / 2);
    m2   = (d >= 1) && (d <= div / 2 + hold);
    cyc  = (d == 1);
    c    = (kk - 1) / div;
    odd  = (c % 2) == 1;
    return {phi0, !phi0, phi0, m2, !phi0 && !odd, !(!phi0 && odd), cyc};
  endfunction

  // Driver tasks
  task automatic hold_reset(input int n);
    n_res = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    n_res = 1'b1;
  endtask

  task automatic run_capture(input int n);
    #1;
    sn[0] = obs_n;
    sp[0] = obs_p;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      sn[i] = obs_n;
      sp[i] = obs_p;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    n_res = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (obs_n !== RST_VEC) begin
        bad++;
        $display("FAIL reset_hold_ntsc got=%b exp=%b", obs_n, RST_VEC);
      end
      total++;
      if (obs_p !== RST_VEC) begin
        bad++;
        $display("FAIL reset_hold_pal got=%b exp=%b", obs_p, RST_VEC);
      end
    end
  endtask

  task automatic test_ntsc_phi();
    int   ks[4] = '{6, 7, 12, 13};
    logic ev[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    hold_reset(2);
    run_capture(32);
    for (int i = 0; i <= 32; i++) begin
      total++;
      if (sn[i] !== model(i, 12, 1)) begin
        bad++;
        $display("FAIL ntsc_model k=%0d got=%b exp=%b", i, sn[i], model(i, 12, 1));
      end
      total++;
      if (sn[i][5] !== ~sn[i][6] || sn[i][4] !== sn[i][6]) begin
        bad++;
        $display("FAIL ntsc_phi12 k=%0d got phi0/1/2=%b required phi1=~phi0 phi2=phi0", i, sn[i][6:4]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sn[ks[i]][6] !== ev[i]) begin
        bad++;
        $display("FAIL ntsc_phi0_edge k=%0d got=%b exp=%b", ks[i], sn[ks[i]][6], ev[i]);
      end
    end
  endtask

  task automatic test_aclk_ntsc();
    int   ka[6] = '{6, 7, 12, 13, 30, 31};
    logic ea[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int   kb[4] = '{18, 19, 24, 25};
    logic eb[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    hold_reset(1);
    run_capture(40);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (sn[ka[i]][2] !== ea[i]) begin
        bad++;
        $display("FAIL ntsc_aclk1 k=%0d got=%b exp=%b", ka[i], sn[ka[i]][2], ea[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sn[kb[i]][1] !== eb[i]) begin
        bad++;
        $display("FAIL ntsc_naclk2 k=%0d got=%b exp=%b", kb[i], sn[kb[i]][1], eb[i]);
      end
    end
    for (int i = 0; i <= 40; i++) begin
      total++;
      if (sn[i][2] === 1'b1 && sn[i][1] === 1'b0) begin
        bad++;
        $display("FAIL ntsc_aclk_overlap k=%0d got aclk1=1 naclk2=0 required not both active", i);
      end
    end
  endtask

  task automatic test_m2_cyc();
    int   km[4] = '{0, 1, 7, 8};
    logic em[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic ec;
    hold_reset(1);
    run_capture(32);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sn[km[i]][3] !== em[i]) begin
        bad++;
        $display("FAIL ntsc_m2 k=%0d got=%b exp=%b", km[i], sn[km[i]][3], em[i]);
      end
    end
    for (int i = 0; i <= 32; i++) begin
      ec = (i == 1) || (i == 13) || (i == 25);
      total++;
      if (sn[i][0] !== ec) begin
        bad++;
        $display("FAIL ntsc_cyc_start k=%0d got=%b exp=%b", i, sn[i][0], ec);
      end
    end
  endtask

  task automatic test_pal();
    int   kp[4] = '{8, 9, 16, 17};
    logic ep[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic e;
    hold_reset(1);
    run_capture(40);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sp[kp[i]][6] !== ep[i]) begin
        bad++;
        $display("FAIL pal_phi0_edge k=%0d got=%b exp=%b", kp[i], sp[kp[i]][6], ep[i]);
      end
    end
    for (int i = 9; i <= 40; i++) begin
      e = (i <= 16);
      total++;
      if (sp[i][2] !== e) begin
        bad++;
        $display("FAIL pal_aclk1 k=%0d got=%b exp=%b", i, sp[i][2], e);
      end
    end
    for (int i = 1; i <= 40; i++) begin
      e = !(i >= 25 && i <= 32);
      total++;
      if (sp[i][1] !== e) begin
        bad++;
        $display("FAIL pal_naclk2 k=%0d got=%b exp=%b", i, sp[i][1], e);
      end
      total++;
      if (sp[i] !== model(i, 16, PAL_HOLD)) begin
        bad++;
        $display("FAIL pal_model k=%0d got=%b exp=%b", i, sp[i], model(i, 16, PAL_HOLD));
      end
    end
  endtask

  task automatic test_mid_reset();
    hold_reset(1);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (obs_n !== model(20, 12, 1)) begin
      bad++;
      $display("FAIL mid_pre_reset k=20 got=%b exp=%b", obs_n, model(20, 12, 1));
    end
    #1;
    n_res = 1'b0;
    #1;
    total++;
    if (obs_n !== RST_VEC) begin
      bad++;
      $display("FAIL mid_async_ntsc got=%b exp=%b", obs_n, RST_VEC);
    end
    total++;
    if (obs_p !== RST_VEC) begin
      bad++;
      $display("FAIL mid_async_pal got=%b exp=%b", obs_p, RST_VEC);
    end
    hold_reset(2);
    run_capture(32);
    for (int i = 0; i <= 32; i++) begin
      total++;
      if (sn[i] !== model(i, 12, 1)) begin
        bad++;
        $display("FAIL mid_restart k=%0d got=%b exp=%b", i, sn[i], model(i, 12, 1));
      end
    end
  endtask

  task automatic test_random();
    int       len;
    logic [6:0] e;
    for (int it = 0; it < 8; it++) begin
      hold_reset($urandom_range(1, 4));
      len = $urandom_range(1, 70);
      for (int i = 1; i <= len; i++) begin
        @(posedge clk);
        #1;
        exp_q.push_back(model(k, 12, 1));
        exp_q.push_back(model(k, 16, PAL_HOLD));
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (obs_n !== e) begin
          bad++;
          $display("FAIL rand_ntsc it=%0d k=%0d got=%b exp=%b", it, k, obs_n, e);
        end
        e = exp_q.pop_front();
        total++;
        if (obs_p !== e) begin
          bad++;
          $display("FAIL rand_pal it=%0d k=%0d got=%b exp=%b", it, k, obs_p, e);
        end
      end
      @(posedge clk);
      #($urandom_range(1, 9));
      n_res = 1'b0;
      #1;
      total++;
      if (obs_n !== RST_VEC || obs_p !== RST_VEC) begin
        bad++;
        $display("FAIL rand_async_reset it=%0d got ntsc=%b pal=%b exp=%b", it, obs_n, obs_p, RST_VEC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ntsc_phi();
    test_aclk_ntsc();
    test_m2_cyc();
    test_pal();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
